// File: rtl/logic_tt_checker.sv
// Sweeps all eight {A,B,C} vectors through the course logic block, samples D/E after a settle
// time, and reports mismatch count, first failing vector and pass/done.
module logic_tt_checker #(
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    input  logic             d_i,
    input  logic             e_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [2:0]       first_err_vec
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] vec;
    logic [3:0] cnt;
    logic       launch;
    logic       settled;
    logic       exp_d;
    logic       exp_e;
    logic       mismatch;

    assign launch   = start && (state == IDLE || state == DONE);
    assign settled  = (cnt == SETTLE_LAST);
    assign exp_d    = (vec[2] & vec[1]) | ~vec[0];
    assign exp_e    = ~vec[0];
    assign mismatch = (d_i != exp_d) || (e_i != exp_e);

    assign a_o = vec[2];
    assign b_o = vec[1];
    assign c_o = vec[0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY:   if (settled) state_nxt = CHECK;
            CHECK:   state_nxt = (vec == 3'd7) ? DONE : APPLY;
            DONE:    if (start) state_nxt = APPLY;
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags decode straight from the state register, so they change only on clock edges.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state)
            APPLY, CHECK: busy = 1'b1;
            DONE: begin
                done = 1'b1;
                pass = (err_cnt == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec           <= 3'd0;
            cnt           <= 4'd0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= 3'd0;
        end else if (launch) begin
            vec           <= 3'd0;
            cnt           <= 4'd0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= 3'd0;
        end else begin
            case (state)
                APPLY: cnt <= cnt + 4'd1;
                CHECK: begin
                    if (mismatch) begin
                        if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                        if (!first_err_vld) begin
                            first_err_vld <= 1'b1;
                            first_err_vec <= vec;
                        end
                    end
                    // The last vector stays on the outputs while in DONE.
                    if (vec != 3'd7) begin
                        vec <= vec + 3'd1;
                        cnt <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_tt_checker.sv
// Bench for logic_tt_checker: three instances (default, ERR_W=2, SETTLE_CYC=1) share clock,
// reset and start, each looped back through a faultable model of the course logic block.
module tb_logic_tt_checker;

    typedef struct {
        logic [2:0] abc;
        logic       busy;
        logic       done;
    } sb_t;

    typedef struct {
        int         mode;
        int         glitch;
        logic [3:0] err4;
        logic [1:0] err2;
        logic       fvld;
        logic [2:0] fvec;
        logic       pass;
    } sweep_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    int   mode = 0;
    int   checks = 0;
    int   failures = 0;

    logic       a0, b0, c0, d0, e0, busy0, done0, pass0, fvld0;
    logic [3:0] err0;
    logic [2:0] fvec0;
    logic       a1, b1, c1, d1, e1, busy1, done1, pass1, fvld1;
    logic [1:0] err1;
    logic [2:0] fvec1;
    logic       a2, b2, c2, d2, e2, busy2, done2, pass2, fvld2;
    logic [3:0] err2;
    logic [2:0] fvec2;

    sb_t q_main[$];
    sb_t q_s1[$];

    always #5 clk = ~clk;

    // Golden block with optional faults: 1 = D stuck 0, 2 = E inverted, 3 = D flipped at 101.
    function automatic logic [1:0] block_resp(input int m, input logic a, input logic b, input logic c);
        logic d;
        logic e;
        d = (a & b) | ~c;
        e = ~c;
        case (m)
            1: d = 1'b0;
            2: e = c;
            3: if ({a, b, c} == 3'b101) d = ~d;
            default: ;
        endcase
        return {d, e};
    endfunction

    assign {d0, e0} = block_resp(mode, a0, b0, c0);
    assign {d1, e1} = block_resp(mode, a1, b1, c1);
    assign {d2, e2} = block_resp(mode, a2, b2, c2);

    logic_tt_checker #(.SETTLE_CYC(2), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a_o(a0), .b_o(b0), .c_o(c0), .d_i(d0), .e_i(e0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_err_vld(fvld0), .first_err_vec(fvec0));

    logic_tt_checker #(.SETTLE_CYC(2), .ERR_W(2)) dut_e2 (
        .clk(clk), .rst(rst), .start(start), .a_o(a1), .b_o(b1), .c_o(c1), .d_i(d1), .e_i(e1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_vld(fvld1), .first_err_vec(fvec1));

    logic_tt_checker #(.SETTLE_CYC(1), .ERR_W(4)) dut_s1 (
        .clk(clk), .rst(rst), .start(start), .a_o(a2), .b_o(b2), .c_o(c2), .d_i(d2), .e_i(e2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_err_vld(fvld2), .first_err_vec(fvec2));

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_abc0", 32'({a0, b0, c0}), 0);
        checkOutput("rst_abc1", 32'({a1, b1, c1}), 0);
        checkOutput("rst_abc2", 32'({a2, b2, c2}), 0);
        checkOutput("rst_flags0", 32'({busy0, done0, pass0, fvld0}), 0);
        checkOutput("rst_flags1", 32'({busy1, done1, pass1, fvld1}), 0);
        checkOutput("rst_flags2", 32'({busy2, done2, pass2, fvld2}), 0);
        checkOutput("rst_err0", 32'(err0), 0);
        checkOutput("rst_err1", 32'(err1), 0);
        checkOutput("rst_err2", 32'(err2), 0);
        checkOutput("rst_fvec0", 32'(fvec0), 0);
    endtask

    // Pushes the expected per-cycle stimulus/status, launches a sweep, and pops one entry per edge.
    task automatic runSweep(input int glitch);
        sb_t e;
        for (int j = 0; j <= 24; j++) begin
            e.abc  = (j < 24) ? 3'(j / 3) : 3'd7;
            e.busy = (j < 24);
            e.done = (j == 24);
            q_main.push_back(e);
            e.abc  = (j < 16) ? 3'(j / 2) : 3'd7;
            e.busy = (j < 16);
            e.done = (j >= 16);
            q_s1.push_back(e);
        end
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        checkOutput("launch_err0", 32'(err0), 0);
        checkOutput("launch_err1", 32'(err1), 0);
        checkOutput("launch_fvld0", 32'(fvld0), 0);
        checkOutput("launch_pass0", 32'(pass0), 0);
        for (int j = 0; j <= 24; j++) begin
            e = q_main.pop_front();
            checkOutput($sformatf("abc0_j%0d", j), 32'({a0, b0, c0}), 32'(e.abc));
            checkOutput($sformatf("bd0_j%0d", j), 32'({busy0, done0}), 32'({e.busy, e.done}));
            checkOutput($sformatf("abc1_j%0d", j), 32'({a1, b1, c1}), 32'(e.abc));
            e = q_s1.pop_front();
            checkOutput($sformatf("abc2_j%0d", j), 32'({a2, b2, c2}), 32'(e.abc));
            checkOutput($sformatf("bd2_j%0d", j), 32'({busy2, done2}), 32'({e.busy, e.done}));
            if (j < 24) begin
                start = (j == glitch);
                applyStimulus();
                start = 1'b0;
            end
        end
        applyStimulus();
        checkOutput("done_hold", 32'({done0, a0, b0, c0}), 32'h0f);
    endtask

    sweep_t tbl[6];

    initial begin
        tbl[0] = '{mode: 0, glitch: -1, err4: 4'd0, err2: 2'd0, fvld: 1'b0, fvec: 3'd0, pass: 1'b1};
        tbl[1] = '{mode: 1, glitch: -1, err4: 4'd5, err2: 2'd3, fvld: 1'b1, fvec: 3'd0, pass: 1'b0};
        tbl[2] = '{mode: 2, glitch: -1, err4: 4'd8, err2: 2'd3, fvld: 1'b1, fvec: 3'd0, pass: 1'b0};
        tbl[3] = '{mode: 3, glitch: -1, err4: 4'd1, err2: 2'd1, fvld: 1'b1, fvec: 3'd5, pass: 1'b0};
        tbl[4] = '{mode: 1, glitch: 9,  err4: 4'd5, err2: 2'd3, fvld: 1'b1, fvec: 3'd0, pass: 1'b0};
        tbl[5] = '{mode: 0, glitch: -1, err4: 4'd0, err2: 2'd0, fvld: 1'b0, fvec: 3'd0, pass: 1'b1};

        // Reset held together with start: reset must win.
        start = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        start = 1'b0;
        checkReset();
        applyStimulus();
        checkOutput("idle_busy0", 32'(busy0), 0);

        for (int i = 0; i < 6; i++) begin
            mode = tbl[i].mode;
            runSweep(tbl[i].glitch);
            checkOutput($sformatf("t%0d_err0", i), 32'(err0), 32'(tbl[i].err4));
            checkOutput($sformatf("t%0d_err1", i), 32'(err1), 32'(tbl[i].err2));
            checkOutput($sformatf("t%0d_err2", i), 32'(err2), 32'(tbl[i].err4));
            checkOutput($sformatf("t%0d_fvld", i), 32'(fvld0), 32'(tbl[i].fvld));
            checkOutput($sformatf("t%0d_fvec", i), 32'(fvec0), 32'(tbl[i].fvec));
            checkOutput($sformatf("t%0d_fvec2", i), 32'(fvec2), 32'(tbl[i].fvec));
            checkOutput($sformatf("t%0d_pass0", i), 32'(pass0), 32'(tbl[i].pass));
            checkOutput($sformatf("t%0d_pass1", i), 32'(pass1), 32'(tbl[i].pass));
        end

        // Reset while the default instance is applying vector 101, with errors already counted.
        mode = 1;
        start = 1'b1;
        applyStimulus();
        start = 1'b0;
        for (int j = 1; j <= 15; j++) applyStimulus();
        checkOutput("pre_rst_abc", 32'({a0, b0, c0}), 32'h5);
        checkOutput("pre_rst_err", 32'(err0), 3);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkReset();
        applyStimulus();
        checkOutput("post_rst_idle", 32'({busy0, done0}), 0);
        mode = 2;
        runSweep(-1);
        checkOutput("fresh_err0", 32'(err0), 8);
        checkOutput("fresh_err1", 32'(err1), 3);
        checkOutput("fresh_fvec", 32'(fvec0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
